// File: rtl/ppu_line_sequencer.sv
// ppu_line_sequencer: fixed-length-line LCD timing sequencer.
// Generates dot/ly counters and the mode 2 -> 3 -> 0 / mode 1 sequence,
// starts the OAM search and pixel transfer engines, and raises the
// STAT (rising-edge, blocking) and VBlank interrupt requests.
module ppu_line_sequencer #(
  parameter int LINE_CYCLES   = 456,
  parameter int VISIBLE_LINES = 144,
  parameter int VBLANK_LINES  = 10,
  parameter int OAM_CYCLES    = 80,
  parameter int LY_W          = 8,
  localparam int DOT_W        = $clog2(LINE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_en,
  input  logic [LY_W-1:0]  lyc,
  input  logic [3:0]       stat_sel,
  input  logic             xfer_done,
  output logic             oam_start,
  output logic             xfer_start,
  output logic [1:0]       mode,
  output logic [LY_W-1:0]  ly,
  output logic [DOT_W-1:0] dot,
  output logic             lyc_match,
  output logic             stat_irq,
  output logic             vblank_irq,
  output logic [DOT_W-1:0] xfer_len,
  output logic             overrun
);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_OAM    = 3'd1;
  localparam logic [2:0] ST_XFER   = 3'd2;
  localparam logic [2:0] ST_HBLANK = 3'd3;
  localparam logic [2:0] ST_VBLANK = 3'd4;

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(LINE_CYCLES - 1);
  localparam logic [DOT_W-1:0] DOT_OAM  = DOT_W'(OAM_CYCLES);
  localparam logic [DOT_W-1:0] XFER_MAX = DOT_W'(LINE_CYCLES - OAM_CYCLES);
  localparam logic [LY_W-1:0]  LY_LAST  = LY_W'(VISIBLE_LINES + VBLANK_LINES - 1);
  localparam logic [LY_W-1:0]  LY_VBL   = LY_W'(VISIBLE_LINES);

  logic [2:0]       state_reg, state_next;
  logic [DOT_W-1:0] dot_next, xfer_len_next, done_len;
  logic [LY_W-1:0]  ly_next;
  logic [1:0]       mode_next;
  logic             oam_start_next, xfer_start_next, vblank_irq_next, overrun_next;
  logic             line_end, xfer_finish;
  logic             lyc_hit, lyc_match_next;
  logic             stat_line, stat_irq_next, line_prev_reg, line_prev_next;

  // Line/state sequencing; lcd_en low overrides every other event.
  always_comb begin
    state_next      = state_reg;
    dot_next        = dot;
    ly_next         = ly;
    mode_next       = mode;
    oam_start_next  = 1'b0;
    xfer_start_next = 1'b0;
    vblank_irq_next = 1'b0;
    xfer_len_next   = xfer_len;
    overrun_next    = overrun;
    line_end        = (dot == DOT_LAST);
    // The xfer_start cycle is excluded so mode 3 lasts at least two dots.
    xfer_finish     = (state_reg == ST_XFER) && !xfer_start && xfer_done;
    done_len        = dot - DOT_OAM + 1'b1;

    if (!lcd_en) begin
      state_next    = ST_OFF;
      dot_next      = '0;
      ly_next       = '0;
      mode_next     = MODE_HBLANK;
      xfer_len_next = '0;
      overrun_next  = 1'b0;
    end else if (state_reg == ST_OFF) begin
      state_next     = ST_OAM;
      dot_next       = '0;
      ly_next        = '0;
      mode_next      = MODE_OAM;
      oam_start_next = 1'b1;
    end else if (line_end) begin
      dot_next = '0;
      ly_next  = (ly == LY_LAST) ? '0 : ly + 1'b1;
      // A finish on the last dot counts as a normal finish, not an overrun.
      if (xfer_finish) begin
        xfer_len_next = done_len;
      end else if (state_reg == ST_XFER) begin
        overrun_next  = 1'b1;
        xfer_len_next = XFER_MAX;
      end
      if (ly_next < LY_VBL) begin
        state_next     = ST_OAM;
        mode_next      = MODE_OAM;
        oam_start_next = 1'b1;
      end else begin
        state_next      = ST_VBLANK;
        mode_next       = MODE_VBLANK;
        vblank_irq_next = (ly_next == LY_VBL);
      end
    end else begin
      dot_next = dot + 1'b1;
      case (state_reg)
        ST_OAM: begin
          if (dot_next == DOT_OAM) begin
            state_next      = ST_XFER;
            mode_next       = MODE_XFER;
            xfer_start_next = 1'b1;
          end
        end
        ST_XFER: begin
          if (xfer_finish) begin
            state_next    = ST_HBLANK;
            mode_next     = MODE_HBLANK;
            xfer_len_next = done_len;
          end
        end
        default: ;
      endcase
    end
  end

  // STAT line and edge detection; compare feeds lyc_match and the STAT line
  // together so stat_irq rises in the same cycle lyc_match does.
  always_comb begin
    lyc_hit        = (ly == lyc);
    lyc_match_next = lcd_en ? lyc_hit : (lyc == '0);
    stat_line      = (lyc_hit & stat_sel[3])
                   | ((mode == MODE_OAM)    & stat_sel[2])
                   | ((mode == MODE_VBLANK) & stat_sel[1])
                   | ((mode == MODE_HBLANK) & stat_sel[0]);
    stat_irq_next  = 1'b0;
    line_prev_next = 1'b0;
    if (lcd_en && (state_reg != ST_OFF)) begin
      stat_irq_next  = stat_line & ~line_prev_reg;
      line_prev_next = stat_line;
    end
  end

  // Output and state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_OFF;
      dot           <= '0;
      ly            <= '0;
      mode          <= MODE_HBLANK;
      oam_start     <= 1'b0;
      xfer_start    <= 1'b0;
      vblank_irq    <= 1'b0;
      stat_irq      <= 1'b0;
      line_prev_reg <= 1'b0;
      lyc_match     <= (lyc == '0);
      xfer_len      <= '0;
      overrun       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dot           <= dot_next;
      ly            <= ly_next;
      mode          <= mode_next;
      oam_start     <= oam_start_next;
      xfer_start    <= xfer_start_next;
      vblank_irq    <= vblank_irq_next;
      stat_irq      <= stat_irq_next;
      line_prev_reg <= line_prev_next;
      lyc_match     <= lyc_match_next;
      xfer_len      <= xfer_len_next;
      overrun       <= overrun_next;
    end
  end

endmodule
